// File: rtl/kart_physics.sv
// kart_physics: per-frame kart heading, 11.4 fixed-point position and speed integrator feeding the renderer.
// Define KART_SAND_SLOWDOWN_EN to add the track-tile lookup and the sand speed cap.

module kart_physics #(
    parameter int unsigned START_X        = 1000,
    parameter int unsigned START_Y        = 1000,
    parameter int unsigned START_DIR      = 0,
    parameter int unsigned TURN_RATE      = 3,
    parameter int unsigned ACCEL          = 2,
    parameter int unsigned BRAKE          = 4,
    parameter int unsigned MAX_SPEED      = 48,
    parameter int unsigned SAND_MAX_SPEED = 16
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               frame_tick_in,
    input  logic               btn_left_in,
    input  logic               btn_right_in,
    input  logic               btn_accel_in,
    input  logic               btn_brake_in,
    output logic [8:0]         trig_addr_out,
    input  logic signed [10:0] cos_in,
    input  logic signed [10:0] sin_in,
    output logic [7:0]         track_addr_out,
    input  logic [3:0]         tile_type_in,
    output logic [8:0]         direction,
    output logic [10:0]        player_x,
    output logic [10:0]        player_y,
    output logic [7:0]         speed_out,
    output logic               busy_out,
    output logic               update_out
);

    localparam int unsigned DIR_W  = 9;
    localparam int unsigned PIX_W  = 11;
    localparam int unsigned POS_W  = 15;
    localparam int unsigned SPD_W  = 8;
    localparam int unsigned PROD_W = 20;
    localparam int unsigned SUM_W  = 17;

    localparam logic [PIX_W-1:0] START_X_PX  = PIX_W'(START_X);
    localparam logic [PIX_W-1:0] START_Y_PX  = PIX_W'(START_Y);
    localparam logic [POS_W-1:0] START_X_POS = {START_X_PX, 4'b0000};
    localparam logic [POS_W-1:0] START_Y_POS = {START_Y_PX, 4'b0000};
    localparam logic [DIR_W-1:0] START_DIR_V = DIR_W'(START_DIR);

    typedef enum logic [3:0] {
        S_IDLE, S_STEER, S_TRIG_W0, S_TRIG_W1, S_MOVE,
        S_TILE_W0, S_TILE_W1, S_SPEED, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q;
    logic               btn_l_q, btn_l_d, btn_r_q, btn_r_d;
    logic               btn_a_q, btn_a_d, btn_b_q, btn_b_d;
    logic [DIR_W-1:0]   dir_q, dir_d, dir_next;
    logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d, cand_x, cand_y;
    logic [SPD_W-1:0]   speed_q, speed_d, spd_new, spd_dec;
    logic [DIR_W-1:0]   direction_q, direction_d;
    logic [PIX_W-1:0]   player_x_q, player_x_d, player_y_q, player_y_d;
    logic               busy_q, busy_d, update_q, update_d;
    logic [DIR_W:0]     dir_plus;
    logic [SPD_W:0]     spd_raw, spd_cap;
    logic signed [PROD_W-1:0] spd_s, cos_s, sin_s, prod_cos, prod_sin, dx, dy;

    // Add a signed 1/16-px step to a position, saturating to 0..32767.
    function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] pos,
                                                 input logic signed [PROD_W-1:0] d);
        logic signed [SUM_W-1:0] sum;
        sum = $signed({2'b00, pos}) + SUM_W'(d);
        if (sum < 0)
            sat_add = '0;
        else if (sum > $signed(SUM_W'(17'h07FFF)))
            sat_add = '1;
        else
            sat_add = sum[POS_W-1:0];
    endfunction

    assign dir_plus = {1'b0, dir_q} + (DIR_W+1)'(TURN_RATE);

    always_comb begin
        dir_next = dir_q;
        if (btn_l_q && !btn_r_q)
            dir_next = (dir_plus >= 10'd360) ? DIR_W'(dir_plus - 10'd360) : DIR_W'(dir_plus);
        else if (btn_r_q && !btn_l_q)
            dir_next = (dir_q < DIR_W'(TURN_RATE)) ? dir_q + DIR_W'(360 - TURN_RATE)
                                                   : dir_q - DIR_W'(TURN_RATE);
    end

    assign spd_s    = PROD_W'($signed({1'b0, speed_q}));
    assign cos_s    = PROD_W'(cos_in);
    assign sin_s    = PROD_W'(sin_in);
    assign prod_cos = spd_s * cos_s;
    assign prod_sin = spd_s * sin_s;
    assign dy       = prod_cos >>> 9;
    assign dx       = -(prod_sin >>> 9);
    assign cand_x   = sat_add(pos_x_q, dx);
    assign cand_y   = sat_add(pos_y_q, dy);

    // Brake wins over accel; with neither pressed, friction takes one unit off.
    always_comb begin
        spd_dec = btn_b_q ? SPD_W'(BRAKE) : SPD_W'(1);
        if (btn_b_q || !btn_a_q)
            spd_raw = (speed_q >= spd_dec) ? {1'b0, speed_q - spd_dec} : '0;
        else
            spd_raw = {1'b0, speed_q} + (SPD_W+1)'(ACCEL);
`ifdef KART_SAND_SLOWDOWN_EN
        spd_cap = (tile_type_in == 4'd1) ? (SPD_W+1)'(SAND_MAX_SPEED) : (SPD_W+1)'(MAX_SPEED);
`else
        spd_cap = (SPD_W+1)'(MAX_SPEED);
`endif
        spd_new = (spd_raw > spd_cap) ? SPD_W'(spd_cap) : SPD_W'(spd_raw);
    end

`ifdef KART_SAND_SLOWDOWN_EN
    logic [7:0] track_q, track_d;
    localparam logic [7:0] START_TRACK = {START_Y_PX[10:7], START_X_PX[10:7]};
    assign track_addr_out = track_q;
`else
    logic unused_cfg;
    assign unused_cfg     = ^{tile_type_in, SPD_W'(SAND_MAX_SPEED)};
    assign track_addr_out = '0;
`endif

    always_comb begin
        state_d     = state_q;
        btn_l_d     = btn_l_q;
        btn_r_d     = btn_r_q;
        btn_a_d     = btn_a_q;
        btn_b_d     = btn_b_q;
        dir_d       = dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        speed_d     = speed_q;
        direction_d = direction_q;
        player_x_d  = player_x_q;
        player_y_d  = player_y_q;
`ifdef KART_SAND_SLOWDOWN_EN
        track_d     = track_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (frame_tick_in && ready_q) begin
                    state_d = S_STEER;
                    btn_l_d = btn_left_in;
                    btn_r_d = btn_right_in;
                    btn_a_d = btn_accel_in;
                    btn_b_d = btn_brake_in;
                end
            end
            S_STEER: begin
                dir_d   = dir_next;
                state_d = S_TRIG_W0;
            end
            S_TRIG_W0: state_d = S_TRIG_W1;
            S_TRIG_W1: state_d = S_MOVE;
            S_MOVE: begin
                pos_x_d = cand_x;
                pos_y_d = cand_y;
`ifdef KART_SAND_SLOWDOWN_EN
                track_d = {cand_y[14:11], cand_x[14:11]};
                state_d = S_TILE_W0;
`else
                state_d = S_SPEED;
`endif
            end
            S_TILE_W0: state_d = S_TILE_W1;
            S_TILE_W1: state_d = S_SPEED;
            // All visible outputs load together on the edge into DONE.
            S_SPEED: begin
                speed_d     = spd_new;
                direction_d = dir_q;
                player_x_d  = pos_x_q[14:4];
                player_y_d  = pos_y_q[14:4];
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d != S_IDLE);
        update_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            btn_l_q     <= 1'b0;
            btn_r_q     <= 1'b0;
            btn_a_q     <= 1'b0;
            btn_b_q     <= 1'b0;
            dir_q       <= START_DIR_V;
            pos_x_q     <= START_X_POS;
            pos_y_q     <= START_Y_POS;
            speed_q     <= '0;
            direction_q <= START_DIR_V;
            player_x_q  <= START_X_PX;
            player_y_q  <= START_Y_PX;
            busy_q      <= 1'b0;
            update_q    <= 1'b0;
`ifdef KART_SAND_SLOWDOWN_EN
            track_q     <= START_TRACK;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            btn_l_q     <= btn_l_d;
            btn_r_q     <= btn_r_d;
            btn_a_q     <= btn_a_d;
            btn_b_q     <= btn_b_d;
            dir_q       <= dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            speed_q     <= speed_d;
            direction_q <= direction_d;
            player_x_q  <= player_x_d;
            player_y_q  <= player_y_d;
            busy_q      <= busy_d;
            update_q    <= update_d;
`ifdef KART_SAND_SLOWDOWN_EN
            track_q     <= track_d;
`endif
        end
    end

    assign trig_addr_out = dir_q;
    assign direction     = direction_q;
    assign player_x      = player_x_q;
    assign player_y      = player_y_q;
    assign speed_out     = speed_q;
    assign busy_out      = busy_q;
    assign update_out    = update_q;

endmodule

// File: tb/tb_kart_physics.sv
// Directed scoreboard bench for kart_physics: a reference model pushes expected frames,
// popped and compared when update_out pulses.

module tb_kart_physics;

`ifdef KART_SAND_SLOWDOWN_EN
    localparam int LAT     = 8;
    localparam int RST_TRK = 8'h77;
`else
    localparam int LAT     = 6;
    localparam int RST_TRK = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, frame_tick, btn_left, btn_right, btn_accel, btn_brake;
    logic [8:0]  trig_addr_out, direction;
    logic signed [10:0] cos_v, sin_v;
    logic [7:0]  track_addr_out, speed_out;
    logic [3:0]  tile_v;
    logic [10:0] player_x, player_y;
    logic        busy_out, update_out;

    kart_physics dut (
        .clk_in(clk), .rst_in_n(rst_n), .frame_tick_in(frame_tick),
        .btn_left_in(btn_left), .btn_right_in(btn_right),
        .btn_accel_in(btn_accel), .btn_brake_in(btn_brake),
        .trig_addr_out(trig_addr_out), .cos_in(cos_v), .sin_in(sin_v),
        .track_addr_out(track_addr_out), .tile_type_in(tile_v),
        .direction(direction), .player_x(player_x), .player_y(player_y),
        .speed_out(speed_out), .busy_out(busy_out), .update_out(update_out)
    );

    typedef struct {int dir; int x; int y; int spd; int trk;} exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int m_dir, m_x, m_y, m_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_pos(input int v);
        if (v < 0) return 0;
        if (v > 32767) return 32767;
        return v;
    endfunction

    // Reference model of one frame update; pushes the expected visible outputs.
    task automatic model_tick(input bit l, input bit r, input bit a, input bit b);
        exp_t e;
        int cs, sn, cap;
        cs = int'(cos_v);
        sn = int'(sin_v);
        if (l && !r)      m_dir = (m_dir + 3) % 360;
        else if (r && !l) m_dir = (m_dir + 357) % 360;
        m_x = clamp_pos(m_x - ((m_s * sn) >>> 9));
        m_y = clamp_pos(m_y + ((m_s * cs) >>> 9));
`ifdef KART_SAND_SLOWDOWN_EN
        cap = (tile_v == 4'd1) ? 16 : 48;
`else
        cap = 48;
`endif
        if (b)      m_s = m_s - 4;
        else if (a) m_s = m_s + 2;
        else        m_s = m_s - 1;
        if (m_s < 0)   m_s = 0;
        if (m_s > cap) m_s = cap;
        e.dir = m_dir;
        e.x   = m_x / 16;
        e.y   = m_y / 16;
        e.spd = m_s;
`ifdef KART_SAND_SLOWDOWN_EN
        e.trk = ((e.y / 128) % 16) * 16 + ((e.x / 128) % 16);
`else
        e.trk = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic compare_frame(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_dir"},   32'(direction),      e.dir);
            check({tag, "_trig"},  32'(trig_addr_out),  e.dir);
            check({tag, "_x"},     32'(player_x),       e.x);
            check({tag, "_y"},     32'(player_y),       e.y);
            check({tag, "_speed"}, 32'(speed_out),      e.spd);
            check({tag, "_track"}, 32'(track_addr_out), e.trk);
        end
    endtask

    task automatic do_tick(input bit l, input bit r, input bit a, input bit b);
        int cnt;
        @(negedge clk);
        btn_left = l; btn_right = r; btn_accel = a; btn_brake = b;
        frame_tick = 1'b1;
        model_tick(l, r, a, b);
        @(negedge clk);
        frame_tick = 1'b0;
        cnt = 1;
        check("busy_first", 32'(busy_out), 1);
        while (update_out !== 1'b1 && cnt < LAT + 4) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, LAT);
        check("busy_done", 32'(busy_out), 1);
        compare_frame("tick");
        @(negedge clk);
        check("update_one_cycle", 32'(update_out), 0);
        check("busy_idle", 32'(busy_out), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dir"},    32'(direction),      0);
        check({tag, "_trig"},   32'(trig_addr_out),  0);
        check({tag, "_x"},      32'(player_x),       1000);
        check({tag, "_y"},      32'(player_y),       1000);
        check({tag, "_speed"},  32'(speed_out),      0);
        check({tag, "_busy"},   32'(busy_out),       0);
        check({tag, "_update"}, 32'(update_out),     0);
        check({tag, "_track"},  32'(track_addr_out), RST_TRK);
    endtask

    initial begin
        int n_upd, first;
        rst_n = 1'b0; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_accel = 1'b0; btn_brake = 1'b0;
        cos_v = 11'sd512; sin_v = 11'sd0; tile_v = 4'd0;
        m_dir = 0; m_x = 16000; m_y = 16000; m_s = 0;

        // Reset state, held and after release
        repeat (3) @(negedge clk);
        check_reset_vals("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_released");

        // Accelerate straight ahead: speed 2..32, y rises by 15 px
        repeat (16) do_tick(0, 0, 1, 0);
        check("accel_speed", 32'(speed_out), 32);
        check("accel_y", 32'(player_y), 1015);
        check("accel_x", 32'(player_x), 1000);

        // Heading wrap in both directions, both buttons hold, friction
        cos_v = 11'sd0; sin_v = 11'sd0;
        do_tick(0, 1, 0, 0); check("wrap_right_0", 32'(direction), 357);
        do_tick(1, 1, 0, 0); check("both_hold",    32'(direction), 357);
        do_tick(1, 0, 0, 0); check("wrap_left_360", 32'(direction), 0);
        do_tick(1, 0, 0, 0); check("left_3",       32'(direction), 3);
        do_tick(0, 1, 0, 0); check("right_to_0",   32'(direction), 0);
        check("friction_speed", 32'(speed_out), 27);

        // Drive diagonally into the low-y / high-x corner and hold there
        cos_v = -11'sd1024; sin_v = -11'sd1024;
        repeat (220) do_tick(0, 0, 1, 0);
        check("clamp_y0",    32'(player_y), 0);
        check("clamp_x2047", 32'(player_x), 2047);
        check("cap_speed",   32'(speed_out), 48);

        // Terrain cap and braking to zero
        cos_v = 11'sd0; sin_v = 11'sd0; tile_v = 4'd1;
        do_tick(0, 0, 1, 0);
`ifdef KART_SAND_SLOWDOWN_EN
        check("sand_cap", 32'(speed_out), 16);
        do_tick(0, 0, 1, 1);
        check("sand_brake", 32'(speed_out), 12);
`else
        check("no_sand_cap", 32'(speed_out), 48);
`endif
        repeat (14) do_tick(0, 0, 0, 1);
        check("brake_floor", 32'(speed_out), 0);
        tile_v = 4'd0;

        // A second tick while busy is dropped
        cos_v = 11'sd512;
        @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0; btn_accel = 1'b1; btn_brake = 1'b0;
        frame_tick = 1'b1;
        model_tick(0, 0, 1, 0);
        n_upd = 0; first = -1;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(negedge clk);
            frame_tick = (c == 3);
            if (c <= LAT) check("rej_busy_high", 32'(busy_out), 1);
            else          check("rej_busy_low",  32'(busy_out), 0);
            if (update_out === 1'b1) begin
                n_upd++;
                if (first < 0) first = c;
            end
        end
        check("rej_update_count", n_upd, 1);
        check("rej_update_cycle", first, LAT);
        compare_frame("rej");

        // Reset in the middle of an update
        @(negedge clk);
        btn_accel = 1'b1;
        frame_tick = 1'b1;
        n_upd = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (update_out === 1'b1) n_upd++;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (update_out === 1'b1) n_upd++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            if (update_out === 1'b1) n_upd++;
        end
        check("midreset_no_update", n_upd, 0);
        check_reset_vals("midreset");
        m_dir = 0; m_x = 16000; m_y = 16000; m_s = 0;
        do_tick(0, 0, 1, 0);
        check("after_reset_speed", 32'(speed_out), 2);
        do_tick(0, 0, 1, 0);
        check("after_reset_y", 32'(player_y), 1000);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
